// File: rtl/mem_responder.sv
// Latency-configurable word memory responder for a multicycle CPU memory port.
// Each R/W strobe is answered through a four-phase ready handshake; bad requests get err.
module mem_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        R,
    input  logic        W,
    input  logic [31:0] W_data,
    output logic [31:0] R_data,
    output logic        ready,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StBusy, StAck, StRel} state_e;

    localparam logic [3:0] CntInit = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       mem [2**ADDR_W];

    logic              req;
    logic              req_bad;
    logic              commit;

    assign req     = R | W;
    assign req_bad = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0) || (R && W);
    assign commit  = (state_q == StBusy) && (cnt_q == 4'd0);

    // State register; storage is deliberately outside the reset domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && write_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Next-state and datapath capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        write_d = write_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    idx_d   = addr[ADDR_W+1:2];
                    wdata_d = W_data;
                    write_d = W;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = StAck;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = CntInit;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StAck;
                    if (!write_q) begin
                        rdata_d = mem[idx_q];
                    end
                end
            end
            StAck: begin
                if (!req) begin
                    state_d = StIdle;
                    err_d   = 1'b0;
                end else begin
                    state_d = StRel;
                end
            end
            StRel: begin
                // A held request is never re-executed; wait for the release.
                if (!req) begin
                    state_d = StIdle;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready  = (state_q == StAck) || (state_q == StRel);
        err    = ready && err_q;
        R_data = rdata_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: four instances cover LATENCY 2, 4, 1 and 15.
module tb_mem_responder;

    localparam int NI = 4;
    localparam int unsigned LAT [NI] = '{2, 4, 1, 15};

    typedef struct {
        int unsigned offset;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst    [NI];
    logic [31:0] addr   [NI];
    logic        r      [NI];
    logic        w      [NI];
    logic [31:0] wd     [NI];
    logic [31:0] rd     [NI];
    logic        rdy    [NI];
    logic        er     [NI];

    exp_t        sb[$];
    logic [31:0] model [int];
    logic [31:0] last_rd [NI];

    int n_checks = 0;
    int n_fails  = 0;

    mem_responder #(.ADDR_W(8), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst[0]), .addr(addr[0]), .R(r[0]), .W(w[0]), .W_data(wd[0]),
        .R_data(rd[0]), .ready(rdy[0]), .err(er[0]));
    mem_responder #(.ADDR_W(8), .LATENCY(4)) u_dut1 (
        .clk(clk), .rst(rst[1]), .addr(addr[1]), .R(r[1]), .W(w[1]), .W_data(wd[1]),
        .R_data(rd[1]), .ready(rdy[1]), .err(er[1]));
    mem_responder #(.ADDR_W(8), .LATENCY(1)) u_dut2 (
        .clk(clk), .rst(rst[2]), .addr(addr[2]), .R(r[2]), .W(w[2]), .W_data(wd[2]),
        .R_data(rd[2]), .ready(rdy[2]), .err(er[2]));
    mem_responder #(.ADDR_W(8), .LATENCY(15)) u_dut3 (
        .clk(clk), .rst(rst[3]), .addr(addr[3]), .R(r[3]), .W(w[3]), .W_data(wd[3]),
        .R_data(rd[3]), .ready(rdy[3]), .err(er[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic release_req(input int k);
        @(negedge clk);
        r[k] = 1'b0;
        w[k] = 1'b0;
        @(posedge clk);
        #1;
        check_eq($sformatf("release_ready%0d", k), 32'(rdy[k]), 32'd0);
        check_eq($sformatf("release_err%0d", k), 32'(er[k]), 32'd0);
    endtask

    // Drive one request, predict its outcome, then wait for ready and compare.
    task automatic access(input int k, input logic rr, input logic ww, input logic [31:0] a,
                          input logic [31:0] d, input bit release_now);
        exp_t        e;
        logic        bad;
        int          key;
        int unsigned n;
        bad = (a[1:0] != 2'b00) || ((a >> 10) != 32'd0) || (rr && ww);
        key = k * 4096 + int'(a >> 2);
        if (!bad && ww) model[key] = d;
        if (!bad && rr) last_rd[k] = model[key];
        e.offset = bad ? 0 : LAT[k];
        e.err    = bad;
        e.rdata  = last_rd[k];
        sb.push_back(e);

        @(negedge clk);
        addr[k] = a;
        r[k]    = rr;
        w[k]    = ww;
        wd[k]   = d;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!rdy[k]) begin
                // Scramble inputs while busy; captured values must be used.
                addr[k] = a ^ 32'h4;
                wd[k]   = ~d;
            end
        end while (!rdy[k] && n < 40);

        e = sb.pop_front();
        check_eq($sformatf("ready%0d@%h", k, a), 32'(rdy[k]), 32'd1);
        check_eq($sformatf("latency%0d@%h", k, a), n - 1, e.offset);
        check_eq($sformatf("err%0d@%h", k, a), 32'(er[k]), 32'(e.err));
        check_eq($sformatf("rdata%0d@%h", k, a), rd[k], e.rdata);
        if (release_now) release_req(k);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b0; addr[k] = 32'd0; r[k] = 1'b0; w[k] = 1'b0; wd[k] = 32'd0;
            last_rd[k] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_ready", 32'(rdy[0]), 32'd0);
        check_eq("reset_err", 32'(er[0]), 32'd0);
        check_eq("reset_rdata", rd[0], 32'd0);
        @(negedge clk);
        for (int k = 0; k < NI; k++) rst[k] = 1'b1;

        // Basic write / read-back and R_data persistence
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rdata_idle_hold", rd[0], 32'hDEADBEEF);

        // Error cases: misaligned, out of range, R and W together
        access(0, 1'b0, 1'b1, 32'h20, 32'h11112222, 1'b1);
        access(0, 1'b0, 1'b1, 32'h12, 32'h00000099, 1'b1);
        access(0, 1'b1, 1'b0, 32'h400, 32'h0, 1'b1);
        access(0, 1'b1, 1'b1, 32'h20, 32'h00000077, 1'b1);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);

        // Hold W through ACK with changing data: exactly one write of captured data
        access(0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) wd[0] = 32'h5;
            @(posedge clk);
            #1;
            check_eq($sformatf("hold_ready%0d", i), 32'(rdy[0]), 32'd1);
        end
        release_req(0);
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1);

        // Reset mid-BUSY aborts the write; earlier committed data survives
        access(1, 1'b0, 1'b1, 32'h40, 32'hAAAA5555, 1'b1);
        access(1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
        @(negedge clk);
        addr[1] = 32'h40; w[1] = 1'b1; wd[1] = 32'h1234;
        repeat (2) @(posedge clk);
        #2;
        rst[1] = 1'b0;
        #1;
        check_eq("abort_ready", 32'(rdy[1]), 32'd0);
        check_eq("abort_rdata", rd[1], 32'd0);
        w[1] = 1'b0;
        last_rd[1] = 32'd0;
        @(negedge clk);
        rst[1] = 1'b1;
        access(1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);

        // Latency sweep at 1 and 15, reads and writes, including the top word
        for (int k = 2; k < NI; k++) begin
            access(k, 1'b0, 1'b1, 32'h8, 32'h01234567 + k, 1'b1);
            access(k, 1'b0, 1'b1, 32'h3FC, 32'h89ABCDEF ^ k, 1'b1);
            access(k, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1);
            access(k, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b1);
            access(k, 1'b0, 1'b1, 32'h6, 32'h0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
